// File: rtl/phase_sequencer_if.sv
// Front-panel / datapath bundle for the instruction-cycle phase sequencer.
// The sequencer uses the slave modport; the front-panel side uses the master modport.
interface phase_sequencer_if #(
    parameter int PHASES    = 5,
    parameter int PHASE_LEN = 2,
    parameter int CNT_W     = 16
);
    localparam int SW = $clog2(PHASES * PHASE_LEN);

    logic              exec_pulse;
    logic              mode_step;
    logic              haltin;
    logic [PHASES-1:0] phase;
    logic [SW-1:0]     slot_out;
    logic              running;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output exec_pulse, mode_step, haltin,
        input  phase, slot_out, running, halted, instr_count
    );

    modport slave (
        input  exec_pulse, mode_step, haltin,
        output phase, slot_out, running, halted, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction-cycle phase generator: PHASES one-hot strobes, PHASE_LEN clocks apart,
// with run / single-step / pause modes and a sticky halt taken only at cycle boundaries.
module phase_sequencer #(
    parameter int PHASES    = 5,
    parameter int PHASE_LEN = 2,
    parameter int CNT_W     = 16
) (
    input  logic            clock,
    input  logic            reset,
    phase_sequencer_if.slave bus
);
    localparam int L  = PHASES * PHASE_LEN;
    localparam int SW = $clog2(L);
    localparam logic [SW-1:0] LAST_SLOT = SW'(L - 1);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     slot_reg, slot_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              halt_pending_reg, halt_pending_next;
    logic              pause_pending_reg, pause_pending_next;
    logic [PHASES-1:0] phase_reg, phase_next;
    logic              run_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            slot_reg          <= '0;
            count_reg         <= '0;
            halt_pending_reg  <= 1'b0;
            pause_pending_reg <= 1'b0;
            phase_reg         <= '0;
        end else begin
            state_reg         <= state_next;
            slot_reg          <= slot_next;
            count_reg         <= count_next;
            halt_pending_reg  <= halt_pending_next;
            pause_pending_reg <= pause_pending_next;
            phase_reg         <= phase_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        slot_next          = slot_reg;
        count_next         = count_reg;
        pause_pending_next = pause_pending_reg;
        // haltin is folded in here so a request on the boundary edge counts for that boundary
        halt_pending_next  = halt_pending_reg | (bus.haltin && (state_reg != HALTED));

        case (state_reg)
            IDLE: begin
                slot_next = '0;
                if (halt_pending_next) begin
                    state_next = HALTED;
                end else if (bus.exec_pulse) begin
                    state_next = bus.mode_step ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if ((state_reg == RUN) && bus.exec_pulse) begin
                    pause_pending_next = 1'b1;
                end
                if (slot_reg == LAST_SLOT) begin
                    slot_next  = '0;
                    count_next = count_reg + CNT_W'(1);
                    if (halt_pending_next) begin
                        state_next = HALTED;
                    end else if ((state_reg == STEP) || pause_pending_reg) begin
                        state_next         = IDLE;
                        pause_pending_next = 1'b0;
                    end
                end else begin
                    slot_next = slot_reg + SW'(1);
                end
            end
            HALTED: begin
                slot_next = '0;
            end
            default: begin
                state_next = IDLE;
                slot_next  = '0;
            end
        endcase
    end

    assign run_next = (state_next == RUN) || (state_next == STEP);

    // Strobes are decoded from next-state so they leave the block registered.
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
        assign phase_next[gi] = run_next && (slot_next == SW'(gi * PHASE_LEN));
    end

    assign bus.phase       = phase_reg;
    assign bus.slot_out    = slot_reg;
    assign bus.running     = (state_reg == RUN) || (state_reg == STEP);
    assign bus.halted      = (state_reg == HALTED);
    assign bus.instr_count = count_reg;
endmodule
